// File: rtl/disp_share_ctrl.sv
// Round-robin owner arbitration for the shared two-digit seven-segment display, with hold time and blank gap.
// Build option: define DISP_IDLE_DASH_EN to show "--" while idle (blank otherwise).
module disp_share_ctrl #(
   parameter int unsigned SCAN_CNT   = 1_250_000,
   parameter int unsigned HOLD_SCANS = 100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  REQ,
   input  logic [31:0] DATA,
   output logic [3:0]  GNT,
   output logic [1:0]  OWNER,
   output logic        BUSY,
   output logic [6:0]  AN,
   output logic        CA
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_GRANT = 2'd1;
   localparam logic [1:0] S_BLANK = 2'd2;

`ifdef DISP_IDLE_DASH_EN
   localparam logic [6:0] IDLE_AN = 7'b1000000;
`else
   localparam logic [6:0] IDLE_AN = 7'b0000000;
`endif

   logic [31:0] cnt;
   logic [31:0] hold;
   logic [31:0] hold_nxt;
   logic [1:0]  state;
   logic [1:0]  state_nxt;
   logic [1:0]  owner_nxt;
   logic        tick;
   logic        ca_nxt;
   logic [1:0]  win;
   logic        win_vld;
   logic [1:0]  idx;
   logic [3:0]  owner_oh;
   logic        others_req;
   logic [7:0]  sel_byte;
   logic [3:0]  sel_nib;
   logic [6:0]  an_nxt;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b0111111;
         4'h1: s = 7'b0000110;
         4'h2: s = 7'b1011011;
         4'h3: s = 7'b1001111;
         4'h4: s = 7'b1100110;
         4'h5: s = 7'b1101101;
         4'h6: s = 7'b1111101;
         4'h7: s = 7'b0000111;
         4'h8: s = 7'b1111111;
         4'h9: s = 7'b1101111;
         4'hA: s = 7'b1110111;
         4'hB: s = 7'b1111100;
         4'hC: s = 7'b0111001;
         4'hD: s = 7'b1011110;
         4'hE: s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   assign tick       = (cnt == SCAN_CNT);
   assign ca_nxt     = CA ^ tick;
   assign owner_oh   = 4'b0001 << OWNER;
   assign others_req = |(REQ & ~owner_oh);

   // Search starts one past the last owner; i == 4 wraps back to the last owner itself.
   always_comb begin
      win     = OWNER;
      win_vld = 1'b0;
      idx     = OWNER;
      for (int unsigned i = 1; i <= 4; i++) begin
         idx = OWNER + i[1:0];
         if (!win_vld && REQ[idx]) begin
            win     = idx;
            win_vld = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = OWNER;
      hold_nxt  = hold;
      case (state)
         S_IDLE: begin
            if (win_vld) begin
               state_nxt = S_GRANT;
               owner_nxt = win;
               hold_nxt  = '0;
            end
         end
         S_GRANT: begin
            if (tick && (hold != HOLD_SCANS))
               hold_nxt = hold + 32'd1;
            if (!REQ[OWNER])
               state_nxt = S_BLANK;
            else if ((hold == HOLD_SCANS) && others_req)
               state_nxt = S_BLANK;
         end
         S_BLANK: begin
            if (tick)
               state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Segment pattern follows the state and digit that will be current after this edge.
   always_comb begin
      sel_byte = DATA[{owner_nxt, 3'b000} +: 8];
      sel_nib  = ca_nxt ? sel_byte[7:4] : sel_byte[3:0];
      case (state_nxt)
         S_GRANT: an_nxt = seg_decode(sel_nib);
         S_BLANK: an_nxt = '0;
         default: an_nxt = IDLE_AN;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt   <= '0;
         CA    <= 1'b0;
         state <= S_IDLE;
         hold  <= '0;
         OWNER <= 2'd3;
         GNT   <= '0;
         BUSY  <= 1'b0;
         AN    <= IDLE_AN;
      end else begin
         cnt   <= tick ? '0 : cnt + 32'd1;
         CA    <= ca_nxt;
         state <= state_nxt;
         hold  <= hold_nxt;
         OWNER <= owner_nxt;
         GNT   <= (state_nxt == S_GRANT) ? (4'b0001 << owner_nxt) : '0;
         BUSY  <= (state_nxt == S_GRANT);
         AN    <= an_nxt;
      end
   end

endmodule
